// File: rtl/bpd_pkg.sv
// Shared constants, FSM state type and helper for the bpd_tour tournament predictor.
package bpd_pkg;

  localparam logic [1:0] GCNT_INIT = 2'b01;
  localparam logic [2:0] LCNT_INIT = 3'b011;
  localparam logic [1:0] CCNT_INIT = 2'b10;

  typedef enum logic [0:0] {
    BPD_INIT  = 1'b0,
    BPD_READY = 1'b1
  } bpd_state_e;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bpd_ctr_tbl.sv
// Saturating-counter table: async read port, retire RMW port with same-index
// forwarding, and an init write port used by the post-reset sweep.
module bpd_ctr_tbl
  import bpd_pkg::*;
#(
  parameter int unsigned      IDX_W    = 12,
  parameter int unsigned      CNT_W    = 2,
  parameter logic [CNT_W-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             upd_vld,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_inc,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [CNT_W-1:0] mem [DEPTH];
  logic             lw_vld;
  logic [IDX_W-1:0] lw_idx;
  logic [CNT_W-1:0] lw_cnt;
  logic [CNT_W-1:0] upd_old;
  logic [CNT_W-1:0] upd_new;

  assign rd_cnt = mem[rd_idx];

  always_comb begin
    upd_old = (lw_vld && (lw_idx == upd_idx)) ? lw_cnt : mem[upd_idx];
    upd_new = upd_old;
    if (upd_inc) begin
      if (upd_old != '1) upd_new = upd_old + CNT_W'(1);
    end else begin
      if (upd_old != '0) upd_new = upd_old - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (init_en)      mem[init_idx] <= INIT_VAL;
    else if (upd_vld) mem[upd_idx]  <= upd_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lw_vld <= 1'b0;
      lw_idx <= '0;
      lw_cnt <= '0;
    end else begin
      lw_vld <= upd_vld & ~init_en;
      lw_idx <= upd_idx;
      lw_cnt <= upd_new;
    end
  end

endmodule

// File: rtl/bpd_tour.sv
// Tournament direction predictor (global/local/choice) with retire-time RMW training.
// Optional macro BPD_PERF_CNT_EN adds update / misprediction counters.
module bpd_tour
  import bpd_pkg::*;
#(
  parameter int unsigned GH_W      = 12,
  parameter int unsigned LH_W      = 10,
  parameter int unsigned BHT_IDX_W = 10,
  parameter int unsigned CH_IDX_W  = 12,
  parameter int unsigned GCNT_W    = 2,
  parameter int unsigned LCNT_W    = 3,
  parameter int unsigned CCNT_W    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [63:0]       pc_f0_i,
  input  logic [63:0]       pc_f1_i,
  input  logic              fill_f1_i,
  input  logic              pred_vld_f1_i,
  input  logic              flush_i,
  input  logic [GH_W-1:0]   flush_bhr_i,
  input  logic              flush_dir_vld_i,
  input  logic              flush_dir_i,
  input  logic              upd_vld_i,
  input  logic [63:0]       upd_pc_i,
  input  logic [GH_W-1:0]   upd_bhr_i,
  input  logic [LH_W-1:0]   upd_lhist_i,
  input  logic              upd_dir_i,
  input  logic              upd_gpred_i,
  input  logic              upd_lpred_i,
  output logic              bpd_rdy_o,
  output logic              bpd_pred_o,
  output logic              bpd_gpred_o,
  output logic              bpd_lpred_o,
  output logic [GH_W-1:0]   bpd_bhr_o,
  output logic [LH_W-1:0]   bpd_lhist_o
`ifdef BPD_PERF_CNT_EN
  ,
  output logic [31:0]       bpd_upd_cnt_o,
  output logic [31:0]       bpd_gmiss_cnt_o,
  output logic [31:0]       bpd_lmiss_cnt_o
`endif
);

  localparam int unsigned IDX_W     = max_w(max_w(GH_W, LH_W), max_w(BHT_IDX_W, CH_IDX_W));
  localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

  bpd_state_e       state;
  logic [IDX_W-1:0] init_idx;
  logic             init_en;
  logic             ready;

  logic [GH_W-1:0]  bhr;
  logic             choice_f1;
  logic [LH_W-1:0]  lhist_f1;
  logic [CCNT_W-1:0] ch_rd;
  logic [GCNT_W-1:0] g_rd;
  logic [LCNT_W-1:0] l_rd;
  logic [LH_W-1:0]  bht_rd;
  logic [LH_W-1:0]  bht [BHT_DEPTH];

  logic                 u_vld;
  logic [GH_W-1:0]      u_gpc;
  logic [CH_IDX_W-1:0]  u_cpc;
  logic [BHT_IDX_W-1:0] u_bpc;
  logic [GH_W-1:0]      u_bhr;
  logic [LH_W-1:0]      u_lhist;
  logic                 u_dir;
  logic                 u_gpred;
  logic                 u_lpred;

  logic                 bht_lw_vld;
  logic [BHT_IDX_W-1:0] bht_lw_idx;
  logic [LH_W-1:0]      bht_lw_data;
  logic [LH_W-1:0]      bht_old;
  logic [LH_W-1:0]      bht_new;

  logic unused_bits;

  assign init_en = (state == BPD_INIT);
  assign ready   = (state == BPD_READY);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BPD_INIT;
      init_idx <= '0;
    end else if (state == BPD_INIT) begin
      init_idx <= init_idx + IDX_W'(1);
      if (&init_idx) state <= BPD_READY;
    end
  end

  // F0: choice and BHT reads, captured into the F1 registers on fill
  assign bht_rd = bht[pc_f0_i[BHT_IDX_W+1:2]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      choice_f1 <= 1'b0;
      lhist_f1  <= '0;
    end else if (fill_f1_i) begin
      choice_f1 <= ch_rd[CCNT_W-1];
      lhist_f1  <= bht_rd;
    end
  end

  assign bpd_rdy_o   = ready;
  assign bpd_gpred_o = ready & g_rd[GCNT_W-1];
  assign bpd_lpred_o = ready & l_rd[LCNT_W-1];
  assign bpd_pred_o  = ready & (choice_f1 ? g_rd[GCNT_W-1] : l_rd[LCNT_W-1]);
  assign bpd_bhr_o   = bhr;
  assign bpd_lhist_o = lhist_f1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bhr <= '0;
    end else if (!ready) begin
      bhr <= '0;
    end else if (flush_i && flush_dir_vld_i) begin
      bhr <= {flush_bhr_i[GH_W-2:0], flush_dir_i};
    end else if (flush_i) begin
      bhr <= flush_bhr_i;
    end else if (pred_vld_f1_i) begin
      bhr <= {bhr[GH_W-2:0], bpd_pred_o};
    end
  end

  // U0: register the retire request; U1 reads, computes and writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u_vld   <= 1'b0;
      u_gpc   <= '0;
      u_cpc   <= '0;
      u_bpc   <= '0;
      u_bhr   <= '0;
      u_lhist <= '0;
      u_dir   <= 1'b0;
      u_gpred <= 1'b0;
      u_lpred <= 1'b0;
    end else begin
      u_vld   <= upd_vld_i & ready;
      u_gpc   <= upd_pc_i[GH_W+1:2];
      u_cpc   <= upd_pc_i[CH_IDX_W+1:2];
      u_bpc   <= upd_pc_i[BHT_IDX_W+1:2];
      u_bhr   <= upd_bhr_i;
      u_lhist <= upd_lhist_i;
      u_dir   <= upd_dir_i;
      u_gpred <= upd_gpred_i;
      u_lpred <= upd_lpred_i;
    end
  end

  bpd_ctr_tbl #(
    .IDX_W   (CH_IDX_W),
    .CNT_W   (CCNT_W),
    .INIT_VAL(CCNT_W'(CCNT_INIT))
  ) u_ch_tbl (
    .clk     (clock),
    .rst_n   (reset_n),
    .rd_idx  (pc_f0_i[CH_IDX_W+1:2]),
    .rd_cnt  (ch_rd),
    .upd_vld (u_vld & (u_gpred != u_lpred)),
    .upd_idx (u_cpc),
    .upd_inc (u_gpred == u_dir),
    .init_en (init_en),
    .init_idx(init_idx[CH_IDX_W-1:0])
  );

  bpd_ctr_tbl #(
    .IDX_W   (GH_W),
    .CNT_W   (GCNT_W),
    .INIT_VAL(GCNT_W'(GCNT_INIT))
  ) u_g_tbl (
    .clk     (clock),
    .rst_n   (reset_n),
    .rd_idx  (pc_f1_i[GH_W+1:2] ^ bhr),
    .rd_cnt  (g_rd),
    .upd_vld (u_vld),
    .upd_idx (u_gpc ^ u_bhr),
    .upd_inc (u_dir),
    .init_en (init_en),
    .init_idx(init_idx[GH_W-1:0])
  );

  bpd_ctr_tbl #(
    .IDX_W   (LH_W),
    .CNT_W   (LCNT_W),
    .INIT_VAL(LCNT_W'(LCNT_INIT))
  ) u_l_tbl (
    .clk     (clock),
    .rst_n   (reset_n),
    .rd_idx  (lhist_f1),
    .rd_cnt  (l_rd),
    .upd_vld (u_vld),
    .upd_idx (u_lhist),
    .upd_inc (u_dir),
    .init_en (init_en),
    .init_idx(init_idx[LH_W-1:0])
  );

  assign bht_old = (bht_lw_vld && (bht_lw_idx == u_bpc)) ? bht_lw_data : bht[u_bpc];
  assign bht_new = {bht_old[LH_W-2:0], u_dir};

  always_ff @(posedge clock) begin
    if (init_en)    bht[init_idx[BHT_IDX_W-1:0]] <= '0;
    else if (u_vld) bht[u_bpc] <= bht_new;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bht_lw_vld  <= 1'b0;
      bht_lw_idx  <= '0;
      bht_lw_data <= '0;
    end else begin
      bht_lw_vld  <= u_vld;
      bht_lw_idx  <= u_bpc;
      bht_lw_data <= bht_new;
    end
  end

`ifdef BPD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bpd_upd_cnt_o   <= '0;
      bpd_gmiss_cnt_o <= '0;
      bpd_lmiss_cnt_o <= '0;
    end else if (u_vld) begin
      bpd_upd_cnt_o <= bpd_upd_cnt_o + 32'd1;
      if (u_gpred != u_dir) bpd_gmiss_cnt_o <= bpd_gmiss_cnt_o + 32'd1;
      if (u_lpred != u_dir) bpd_lmiss_cnt_o <= bpd_lmiss_cnt_o + 32'd1;
    end
  end
`endif

  assign unused_bits = ^{pc_f0_i, pc_f1_i, upd_pc_i, flush_bhr_i, ch_rd, g_rd, l_rd, bht_old};

endmodule

// File: doc/bpd_tour.md
Name: bpd_tour

Overview:
- Parametrised tournament direction predictor. Generalises the fixed 12-bit global / 10-bit local first-stage predictor.
- Sits in fetch. The choice table and BHT are read in F0; the global PHT and local PHT are read in F1. The final direction is produced in F1.
- Retire-time training uses a pipelined read-modify-write path with same-index forwarding.
- Storage arrays are not reset, so a post-reset sweep FSM initialises them.

Parameters:
- GH_W, 12, global history bits; global PHT depth is 2^GH_W.
- LH_W, 10, local history bits per BHT entry; local PHT depth is 2^LH_W.
- BHT_IDX_W, 10, BHT index bits, taken from pc[BHT_IDX_W+1:2].
- CH_IDX_W, 12, choice PHT index bits, taken from pc[CH_IDX_W+1:2].
- GCNT_W, 2, global counter width.
- LCNT_W, 3, local counter width.
- CCNT_W, 2, choice counter width.

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- pc_f0_i  in  64  F0 fetch PC
- pc_f1_i  in  64  F1 fetch PC
- fill_f1_i  in  1  advance F0 read results into F1 registers
- pred_vld_f1_i  in  1  F1 holds a valid conditional branch; shift the speculative BHR
- flush_i  in  1  retire flush; repair the BHR
- flush_bhr_i  in  GH_W  checkpointed BHR of the flushing branch
- flush_dir_vld_i  in  1  the flushing instruction is a conditional branch
- flush_dir_i  in  1  its resolved direction
- upd_vld_i  in  1  retire update request (no backpressure)
- upd_pc_i  in  64  PC of the retiring branch
- upd_bhr_i  in  GH_W  BHR checkpoint of the retiring branch
- upd_lhist_i  in  LH_W  local-history checkpoint of the retiring branch
- upd_dir_i  in  1  resolved direction
- upd_gpred_i  in  1  global prediction made at fetch
- upd_lpred_i  in  1  local prediction made at fetch
- bpd_rdy_o  out  1  initialisation sweep complete
- bpd_pred_o  out  1  final F1 direction
- bpd_gpred_o  out  1  F1 global prediction, checkpointed by the bob
- bpd_lpred_o  out  1  F1 local prediction, checkpointed by the bob
- bpd_bhr_o  out  GH_W  current speculative BHR
- bpd_lhist_o  out  LH_W  F1 local history

Behaviour:
- FSM has two states, INIT and READY. Reset enters INIT.
- INIT sweep:
  - Index counter of width max(GH_W, LH_W, BHT_IDX_W, CH_IDX_W) starts at 0 and steps one entry per cycle.
  - Each table is written at counter[its_idx_w-1:0] with its init value: global 01, local 011, choice 10, BHT 0.
  - Transition to READY when the counter reaches all-ones; bpd_rdy_o goes to 1 the following cycle.
- During INIT:
  - bpd_pred_o, bpd_gpred_o and bpd_lpred_o are 0.
  - Updates and pred_vld_f1_i are ignored; flush_i is ignored.
  - The BHR is held at 0.
  - A reset asserted mid-sweep restarts the sweep at 0.
- Reset values: bhr 0; the F1 registers (choice bit, lhist) 0; bpd_rdy_o 0; all outputs 0.
- Reads:
  - All arrays are asynchronous-read.
  - F1 registers load on fill_f1_i and hold otherwise.
  - Global index = pc_f1_i[GH_W+1:2] ^ bhr. Local index = lhist_f1.
  - bpd_pred_o = choice_f1 ? gpred : lpred. Each prediction is the counter MSB.
- BHR update, in priority order:
  1. flush_i with flush_dir_vld_i: bhr = {flush_bhr_i[GH_W-2:0], flush_dir_i}.
  2. flush_i alone: bhr = flush_bhr_i.
  3. pred_vld_f1_i: bhr = {bhr[GH_W-2:0], bpd_pred_o}.
  4. Otherwise: hold.
- Update pipeline:
  - U0 registers the request.
  - U1 reads the global counter at upd_pc[GH_W+1:2] ^ upd_bhr, the local counter at upd_lhist, the choice counter and the BHT entry. It computes new values and writes them at the end of U1.
  - Throughput is one update per cycle.
- Counter arithmetic: saturating, +1 if taken and -1 if not; clamp at 0 and at 2^W-1.
- Choice training: written only when gpred != lpred; moves toward global when gpred == dir, else toward local.
- BHT training: entry <= {old[LH_W-2:0], dir}.
- Forwarding: if a U1 read index equals the index being written by the previous U1 in the same cycle, the just-written value is used, for each table independently.
- A fetch read at an index written in the same cycle returns the old value.
- Flush and update in the same cycle proceed independently.

Optional Feature:
- Macro BPD_PERF_CNT_EN.
- When defined, adds outputs bpd_upd_cnt_o[31:0], bpd_gmiss_cnt_o[31:0] and bpd_lmiss_cnt_o[31:0].
  - The three counters count U1 updates, U1 updates with gpred != dir, and U1 updates with lpred != dir.
  - They are reset to 0 and wrap on overflow.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package bpd_pkg holds the init constants (GCNT_INIT, LCNT_INIT, CCNT_INIT) and the FSM state encoding (BPD_INIT, BPD_READY).
- One sub-module, bpd_ctr_tbl, parametrised by depth and width:
  - async read port, RMW update port with same-index forwarding, init write port.
  - instantiated for the choice, global and local tables.
- The BHT is inline.

Test Plan:
- Reset release -> bpd_rdy_o is 0 for 4096 cycles (defaults), then 1. Reads at indices 0, 4095 and 1023 return 01 / 011 / 10 / 0.
- After ready, 3 taken updates at pc 0x1000, bhr 0, lhist 0 -> global counter at idx 0x400 = 11; local counter at idx 0 = 110; BHT entry 0x000 = 0x007.
- Back-to-back updates to the same index on consecutive cycles, both taken, starting at 01 -> counter = 11 (forwarding verified, no lost update).
- flush_i with flush_bhr_i = 0xABC and flush_dir_vld_i = 1, flush_dir_i = 1, together with pred_vld_f1_i -> bhr = 0x579; flush wins.
- Choice counter at 10; update with gpred = 0, lpred = 1, dir = 1 -> choice = 01, and the next F1 prediction for that pc selects local.
- Choice test repeated with gpred == lpred -> choice counter unchanged.
